apb_req_master: RTL and testbench
=================================

# apb_req_master

APB requester (initiator) that turns a simple valid/ready request stream into APB3 transfers toward register-file responders such as the SPI control block. It owns the SETUP/ACCESS sequencing, waits on `pready_i` with a bounded timeout, and returns one response (read data plus error flag) per request. It sits between the system command sequencer and the APB fabric in the SPI subsystem.

## Interface
- `ADDR_W`, 32, width of request and APB address.
- `TIMEOUT`, 16, maximum ACCESS cycles with `pready_i` low before the transfer is aborted; 0 disables the timeout.
- `pclk_i` in 1: clock, all logic on rising edge.
- `prst_i` in 1: reset, synchronous, active-high.
- `req_valid_i` in 1: request present.
- `req_ready_o` out 1: request accepted when high together with `req_valid_i`.
- `req_write_i` in 1: 1 write, 0 read.
- `req_addr_i` in ADDR_W: target byte address.
- `req_wdata_i` in 32: write data.
- `rsp_valid_o` out 1: one-cycle pulse, response available.
- `rsp_rdata_o` out 32: read data; 0 for writes.
- `rsp_err_o` out 1: `pslverr_i` seen or timeout.
- `psel_o`, `penable_o`, `pwrite_o` out 1 each; `paddr_o` out ADDR_W; `pwdata_o` out 32.
- `prdata_i` in 32, `pready_i` in 1, `pslverr_i` in 1: responder side.

## Operation
- **FSM states:** IDLE, SETUP, ACCESS.
- **IDLE**
  - `req_ready_o`=1.
  - On `req_valid_i`: latch addr/write/wdata into `paddr_o`/`pwrite_o`/`pwdata_o`, assert `psel_o`, go to SETUP.
- **SETUP**
  - `psel_o`=1, `penable_o`=0.
  - Unconditionally go to ACCESS and assert `penable_o`.
- **ACCESS**
  - `psel_o`=`penable_o`=1. Wait counter increments each cycle `pready_i`=0.
  - **Completion:** `pready_i`=1 completes the transfer.
    - `rsp_rdata_o` = `prdata_i` for reads, 0 for writes.
    - `rsp_err_o` = `pslverr_i`.
    - `rsp_valid_o` pulses the next cycle. `psel_o`/`penable_o` drop. Go to IDLE.
  - **Timeout** (TIMEOUT≠0, counter reaches TIMEOUT with `pready_i` still 0):
    - Abort: drop `psel_o`/`penable_o`, return to IDLE.
    - Respond with `rsp_err_o`=1 and `rsp_rdata_o`=32'h0BAD_DA7A for both reads and writes.
- **Width and signal rules**
  - Counter width is $clog2(TIMEOUT+1). The counter clears on entry to SETUP.
  - `pslverr_i` and `prdata_i` are sampled only when `pready_i`=1 in ACCESS.
  - Request inputs are ignored outside IDLE.
  - `paddr_o`, `pwrite_o`, `pwdata_o` are stable from SETUP through end of ACCESS. They hold their last value while IDLE.
  - `rsp_rdata_o` and `rsp_err_o` hold until the next response.
- **Simultaneous events**
  - `pready_i`=1 in the same cycle the counter hits TIMEOUT: normal completion wins, no timeout error.
- **Reset**
  - Outputs: `psel_o`, `penable_o`, `pwrite_o`, `paddr_o`, `pwdata_o`, `rsp_valid_o`, `rsp_rdata_o`, `rsp_err_o` all 0.
  - State: FSM returns to IDLE, counter is 0.
  - `req_ready_o` is 0 while `prst_i` is high.
- **Reset mid-transfer:** at the next edge, the bus is released, no response is issued, and the pending request is discarded.

## Timing
- **Accept to first ACCESS:** request accepted at edge t → SETUP at t+1 → ACCESS at t+2.
- **Zero-wait transfer:** with `pready_i`=1, `rsp_valid_o`=1 during cycle t+3 and `req_ready_o`=1 in that same cycle. The next request can be accepted at t+3.
- **Throughput:** 1 transfer per 3 cycles.
- **Wait states:** each cycle of `pready_i`=0 adds one cycle to the latency.
- **Timeout latency:** ACCESS lasts TIMEOUT cycles. `rsp_valid_o` asserts in the cycle after the last ACCESS cycle.
- **Response pulse:** `rsp_valid_o` is never high for 2 consecutive cycles.
- **Combinational paths:** there are no combinational paths from APB inputs to APB outputs. `req_ready_o` is the only combinational output and decodes state plus reset.

## Test plan
- **Zero-wait write:** write addr 0x14, data 0x0000_0301, `pready_i` tied 1.
  - Response: `psel_o` high 2 cycles, `penable_o` high 1 cycle.
  - `pwdata_o`=0x0000_0301 throughout. `rsp_valid_o` at t+3 with err=0, rdata=0.
- **Read with wait states:** read 0x10, `pready_i` low 3 ACCESS cycles then high, `prdata_i`=0xA5A5_1234.
  - Response: `rsp_valid_o` at t+6, `rsp_rdata_o`=0xA5A5_1234, err=0.
  - `paddr_o` stable throughout.
- **Timeout:** TIMEOUT=4, `pready_i` held 0.
  - Response: ACCESS lasts exactly 4 cycles, then bus released.
  - `rsp_err_o`=1, rdata=0x0BAD_DA7A.
  - Repeat with `pready_i`=1 on the 4th cycle: must give err=0.
- **Slave error:** `pslverr_i`=1 with `pready_i`=1 on a read.
  - Response: `rsp_err_o`=1, `rsp_rdata_o`=`prdata_i`.
  - `pslverr_i`=1 while `pready_i`=0 must be ignored.
- **Back-to-back:** `req_valid_i` held high for 4 requests (writes 0x00, 0x04, 0x08, then read 0x10), `pready_i`=1.
  - Response: exactly 4 `rsp_valid_o` pulses, 3 cycles apart.
  - Order and data must match; no request dropped or duplicated.
- **Reset mid-ACCESS:** assert `prst_i` for 1 cycle during a wait-stated read.
  - Response: next cycle `psel_o`=`penable_o`=0 and `rsp_valid_o` never pulses for that request.
  - After reset release, a new read completes normally.

Source files
------------

// File: rtl/apb_req_master.sv
// APB3 requester: converts a valid/ready request stream into SETUP/ACCESS
// transfers, bounds the ACCESS phase with an optional timeout, and returns
// one response (read data plus error flag) per accepted request.
module apb_req_master #(
  parameter int ADDR_W  = 32,
  parameter int TIMEOUT = 16
) (
  input  logic              pclk_i,
  input  logic              prst_i,
  // request side
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic              req_write_i,
  input  logic [ADDR_W-1:0] req_addr_i,
  input  logic [31:0]       req_wdata_i,
  // response side
  output logic              rsp_valid_o,
  output logic [31:0]       rsp_rdata_o,
  output logic              rsp_err_o,
  // APB requester side
  output logic              psel_o,
  output logic              penable_o,
  output logic              pwrite_o,
  output logic [ADDR_W-1:0] paddr_o,
  output logic [31:0]       pwdata_o,
  input  logic [31:0]       prdata_i,
  input  logic              pready_i,
  input  logic              pslverr_i
);

  // A zero TIMEOUT still needs a legal one-bit counter.
  localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  // Counter value seen during the last permitted wait cycle of ACCESS.
  localparam logic [CNT_W-1:0] CNT_LAST = (TIMEOUT > 0) ? CNT_W'(TIMEOUT - 1) : '0;
  localparam logic [31:0] TIMEOUT_RDATA = 32'h0BAD_DA7A;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2
  } state_e;

  state_e            state_q;
  logic [CNT_W-1:0]  wait_cnt_q;
  logic              psel_q;
  logic              penable_q;
  logic              pwrite_q;
  logic [ADDR_W-1:0] paddr_q;
  logic [31:0]       pwdata_q;
  logic              rsp_valid_q;
  logic [31:0]       rsp_rdata_q;
  logic              rsp_err_q;
  logic              req_ready_s;

  // Ready decodes only the state and reset, so no APB input reaches it.
  always_comb begin
    req_ready_s = 1'b0;
    if (prst_i) begin
      req_ready_s = 1'b0;
    end else if (state_q == ST_IDLE) begin
      req_ready_s = 1'b1;
    end else begin
      req_ready_s = 1'b0;
    end
  end

  // Transfer sequencer: state, wait counter, APB drive and response registers.
  always_ff @(posedge pclk_i) begin
    if (prst_i) begin
      state_q     <= ST_IDLE;
      wait_cnt_q  <= '0;
      psel_q      <= 1'b0;
      penable_q   <= 1'b0;
      pwrite_q    <= 1'b0;
      paddr_q     <= '0;
      pwdata_q    <= 32'h0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= 32'h0;
      rsp_err_q   <= 1'b0;
    end else begin
      // The response strobe is a single-cycle pulse unless set below.
      rsp_valid_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (req_valid_i) begin
            paddr_q    <= req_addr_i;
            pwrite_q   <= req_write_i;
            pwdata_q   <= req_wdata_i;
            psel_q     <= 1'b1;
            penable_q  <= 1'b0;
            wait_cnt_q <= '0;
            state_q    <= ST_SETUP;
          end else begin
            psel_q    <= 1'b0;
            penable_q <= 1'b0;
          end
        end
        ST_SETUP: begin
          penable_q <= 1'b1;
          state_q   <= ST_ACCESS;
        end
        ST_ACCESS: begin
          // Completion is checked first so a ready on the final wait cycle wins.
          if (pready_i) begin
            rsp_valid_q <= 1'b1;
            rsp_rdata_q <= pwrite_q ? 32'h0 : prdata_i;
            rsp_err_q   <= pslverr_i;
            psel_q      <= 1'b0;
            penable_q   <= 1'b0;
            state_q     <= ST_IDLE;
          end else if ((TIMEOUT != 0) && (wait_cnt_q == CNT_LAST)) begin
            rsp_valid_q <= 1'b1;
            rsp_rdata_q <= TIMEOUT_RDATA;
            rsp_err_q   <= 1'b1;
            psel_q      <= 1'b0;
            penable_q   <= 1'b0;
            state_q     <= ST_IDLE;
          end else begin
            wait_cnt_q <= wait_cnt_q + CNT_W'(1);
          end
        end
        default: begin
          psel_q    <= 1'b0;
          penable_q <= 1'b0;
          state_q   <= ST_IDLE;
        end
      endcase
    end
  end

  assign req_ready_o = req_ready_s;
  assign rsp_valid_o = rsp_valid_q;
  assign rsp_rdata_o = rsp_rdata_q;
  assign rsp_err_o   = rsp_err_q;
  assign psel_o      = psel_q;
  assign penable_o   = penable_q;
  assign pwrite_o    = pwrite_q;
  assign paddr_o     = paddr_q;
  assign pwdata_o    = pwdata_q;

endmodule

// File: tb/tb_apb_req_master.sv
// Directed self-checking bench for apb_req_master (TIMEOUT=4).
module tb_apb_req_master;

  localparam int ADDR_W  = 32;
  localparam int TIMEOUT = 4;

  logic              pclk = 1'b0;
  logic              prst = 1'b1;
  logic              req_valid = 1'b0;
  logic              req_ready;
  logic              req_write = 1'b0;
  logic [ADDR_W-1:0] req_addr = '0;
  logic [31:0]       req_wdata = 32'h0;
  logic              rsp_valid;
  logic [31:0]       rsp_rdata;
  logic              rsp_err;
  logic              psel;
  logic              penable;
  logic              pwrite;
  logic [ADDR_W-1:0] paddr;
  logic [31:0]       pwdata;
  logic [31:0]       prdata = 32'h0;
  logic              pready = 1'b0;
  logic              pslverr = 1'b0;

  int checks = 0;
  int errors = 0;

  apb_req_master #(.ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)) dut (
    .pclk_i     (pclk),
    .prst_i     (prst),
    .req_valid_i(req_valid),
    .req_ready_o(req_ready),
    .req_write_i(req_write),
    .req_addr_i (req_addr),
    .req_wdata_i(req_wdata),
    .rsp_valid_o(rsp_valid),
    .rsp_rdata_o(rsp_rdata),
    .rsp_err_o  (rsp_err),
    .psel_o     (psel),
    .penable_o  (penable),
    .pwrite_o   (pwrite),
    .paddr_o    (paddr),
    .pwdata_o   (pwdata),
    .prdata_i   (prdata),
    .pready_i   (pready),
    .pslverr_i  (pslverr)
  );

  always #5 pclk = ~pclk;

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge pclk);
    #1;
  endtask

  // Issue one request, hold pready low for 'waits' ACCESS cycles, then check the response.
  task automatic do_xfer(input string tag, input logic wr, input logic [31:0] addr,
                         input logic [31:0] wdata, input int waits, input logic [31:0] rd_in,
                         input logic err_in, input logic [31:0] exp_rdata, input logic exp_err,
                         input int exp_lat);
    int cyc, acc, sel_n, lat;
    bit stable;
    cyc = 0; acc = 0; sel_n = 0; lat = -1; stable = 1'b1;
    req_valid = 1'b1; req_write = wr; req_addr = addr; req_wdata = wdata;
    pready  = (waits == 0);
    pslverr = (waits == 0) ? err_in : 1'b1;
    prdata  = (waits == 0) ? rd_in : 32'hDEAD_BEEF;
    check_eq({tag, "_ready"}, 64'(req_ready), 64'd1);
    while (lat < 0 && cyc < 40) begin
      tick();
      cyc++;
      // Scramble request inputs after acceptance; the bus must keep the latched copy.
      req_valid = 1'b0; req_write = ~wr; req_addr = 32'hFFFF_FFF0; req_wdata = ~wdata;
      if (psel) begin
        sel_n++;
        if (paddr !== addr || pwrite !== wr || pwdata !== wdata) stable = 1'b0;
      end
      if (psel && penable) begin
        acc++;
        if (acc == waits + 1) begin
          pready = 1'b1; prdata = rd_in; pslverr = err_in;
        end else begin
          pready = 1'b0; prdata = 32'hDEAD_BEEF; pslverr = 1'b1;
        end
      end
      if (rsp_valid) lat = cyc;
    end
    check_eq({tag, "_latency"}, 64'(lat), 64'(exp_lat));
    check_eq({tag, "_psel_cycles"}, 64'(sel_n), 64'(exp_lat - 1));
    check_eq({tag, "_penable_cycles"}, 64'(acc), 64'(exp_lat - 2));
    check_eq({tag, "_bus_stable"}, 64'(stable), 64'd1);
    check_eq({tag, "_rdata"}, 64'(rsp_rdata), 64'(exp_rdata));
    check_eq({tag, "_err"}, 64'(rsp_err), 64'(exp_err));
    check_eq({tag, "_bus_released"}, 64'({psel, penable}), 64'd0);
    check_eq({tag, "_ready_at_rsp"}, 64'(req_ready), 64'd1);
    tick();
    check_eq({tag, "_pulse_one_cycle"}, 64'(rsp_valid), 64'd0);
    check_eq({tag, "_rdata_hold"}, 64'(rsp_rdata), 64'(exp_rdata));
  endtask

  logic [31:0] b2b_addr [4];
  logic        b2b_wr   [4];
  logic [31:0] b2b_exp  [4];

  initial begin
    int k, n, setup_n;
    bit prev_v, seen;

    // Reset state
    repeat (3) tick();
    check_eq("rst_ready", 64'(req_ready), 64'd0);
    check_eq("rst_bus", 64'({psel, penable, pwrite}), 64'd0);
    check_eq("rst_paddr", 64'(paddr), 64'd0);
    check_eq("rst_pwdata", 64'(pwdata), 64'd0);
    check_eq("rst_rsp", 64'({rsp_valid, rsp_err}), 64'd0);
    check_eq("rst_rdata", 64'(rsp_rdata), 64'd0);
    prst = 1'b0;
    #1;
    check_eq("rst_release_ready", 64'(req_ready), 64'd1);
    tick();

    // Directed vectors; pslverr is held high during wait cycles and must be ignored.
    do_xfer("wr_zero_wait",   1'b1, 32'h14, 32'h0000_0301, 0,  32'h0,         1'b0, 32'h0,         1'b0, 3);
    do_xfer("rd_wait3",       1'b0, 32'h10, 32'h0,         3,  32'hA5A5_1234, 1'b0, 32'hA5A5_1234, 1'b0, 6);
    do_xfer("rd_timeout",     1'b0, 32'h20, 32'h0,         99, 32'h0,         1'b0, 32'h0BAD_DA7A, 1'b1, 6);
    do_xfer("wr_timeout",     1'b1, 32'h24, 32'h55,        99, 32'h0,         1'b0, 32'h0BAD_DA7A, 1'b1, 6);
    do_xfer("rd_ready_last",  1'b0, 32'h28, 32'h0,         3,  32'h1111_2222, 1'b0, 32'h1111_2222, 1'b0, 6);
    do_xfer("rd_slverr",      1'b0, 32'h30, 32'h0,         0,  32'hCAFE_F00D, 1'b1, 32'hCAFE_F00D, 1'b1, 3);
    do_xfer("wr_slverr_wait", 1'b1, 32'h34, 32'h77,        2,  32'h9999_9999, 1'b1, 32'h0,         1'b1, 5);

    // Back-to-back: valid held high for three writes and a read, zero wait.
    b2b_addr = '{32'h00, 32'h04, 32'h08, 32'h10};
    b2b_wr   = '{1'b1, 1'b1, 1'b1, 1'b0};
    b2b_exp  = '{32'h0, 32'h0, 32'h0, 32'h7777_0010};
    pready = 1'b1; pslverr = 1'b0; prdata = 32'h7777_0010;
    k = 0; n = 0; setup_n = 0; prev_v = 1'b0;
    req_valid = 1'b1; req_write = b2b_wr[0]; req_addr = b2b_addr[0]; req_wdata = 32'h100;
    for (int c = 1; c <= 15; c++) begin
      if (req_ready && req_valid) k++;
      tick();
      if (k < 4) begin
        req_write = b2b_wr[k]; req_addr = b2b_addr[k]; req_wdata = 32'h100 + 32'(k);
      end else begin
        req_valid = 1'b0;
      end
      if (psel && !penable && setup_n < 4) begin
        check_eq("b2b_setup_addr", 64'(paddr), 64'(b2b_addr[setup_n]));
        check_eq("b2b_setup_write", 64'(pwrite), 64'(b2b_wr[setup_n]));
        setup_n++;
      end
      if (rsp_valid) begin
        check_eq("b2b_no_double_pulse", 64'(prev_v), 64'd0);
        if (n < 4) begin
          check_eq("b2b_rsp_cycle", 64'(c), 64'(3 * (n + 1)));
          check_eq("b2b_rsp_rdata", 64'(rsp_rdata), 64'(b2b_exp[n]));
          check_eq("b2b_rsp_err", 64'(rsp_err), 64'd0);
        end
        n++;
      end
      prev_v = rsp_valid;
    end
    check_eq("b2b_rsp_count", 64'(n), 64'd4);
    check_eq("b2b_setup_count", 64'(setup_n), 64'd4);

    // Reset during a wait-stated read ACCESS.
    pready = 1'b0; pslverr = 1'b0;
    req_valid = 1'b1; req_write = 1'b0; req_addr = 32'h40;
    tick();
    req_valid = 1'b0;
    tick();
    tick();
    check_eq("mid_in_access", 64'({psel, penable}), 64'd3);
    prst = 1'b1;
    #1;
    check_eq("mid_ready_in_rst", 64'(req_ready), 64'd0);
    tick();
    prst = 1'b0;
    check_eq("mid_bus_released", 64'({psel, penable}), 64'd0);
    check_eq("mid_rdata_cleared", 64'(rsp_rdata), 64'd0);
    pready = 1'b1; prdata = 32'h5A5A_5A5A;
    seen = 1'b0;
    for (int c = 0; c < 8; c++) begin
      if (rsp_valid) seen = 1'b1;
      tick();
    end
    check_eq("mid_no_response", 64'(seen), 64'd0);
    do_xfer("rd_after_rst", 1'b0, 32'h44, 32'h0, 1, 32'h0123_4567, 1'b0, 32'h0123_4567, 1'b0, 4);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
